// File: rtl/ps2_frame_assembler.sv
// Packs PS/2 receiver bytes into NBYTES-wide frames behind a one-deep output holding register,
// with a sticky overflow flag and an optional inter-byte timeout that drops partial frames.
module ps2_frame_assembler #(
   parameter int unsigned NBYTES      = 4,
   parameter int unsigned DW          = 8,
   parameter int unsigned ORDER       = 0,
   parameter int unsigned TIMEOUT_CYC = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             tick,
   input  logic [DW-1:0]                    d,
   input  logic                             ack,
   input  logic                             clear_ovf,
   output logic [NBYTES*DW-1:0]             data,
   output logic                             valid,
   output logic [$clog2(NBYTES+1)-1:0]      count,
   output logic                             overflow,
   output logic                             timeout
);

   localparam int unsigned CW = $clog2(NBYTES + 1);
   localparam int unsigned IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [IW-1:0] IdleMax = IW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [CW-1:0] LastIdx = CW'(NBYTES - 1);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e                 state_q, state_d;
   logic [NBYTES*DW-1:0]   asm_q, asm_d;
   logic [NBYTES*DW-1:0]   data_q, data_d;
   logic [CW-1:0]          idx_q, idx_d;
   logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
   logic                   overflow_q, overflow_d;
   logic                   timeout_q, timeout_d;
   logic                   complete;
   logic                   expire;

   always_comb begin
      asm_d      = asm_q;
      data_d     = data_q;
      idx_d      = idx_q;
      state_d    = state_q;
      overflow_d = overflow_q;
      idle_cnt_d = idle_cnt_q;

      complete = tick && (idx_q == LastIdx);
      // A tick in the expiry cycle keeps the partial frame alive.
      expire   = (TIMEOUT_CYC > 0) && !tick && (idx_q != '0) && (idle_cnt_q == IdleMax);

      for (int unsigned s = 0; s < NBYTES; s++) begin
         if (tick && (idx_q == CW'((ORDER == 0) ? (NBYTES - 1 - s) : s))) begin
            asm_d[s*DW +: DW] = d;
         end
      end

      if (tick) begin
         idx_d = complete ? '0 : idx_q + CW'(1);
      end else if (expire) begin
         idx_d = '0;
      end

      if (clear_ovf) begin
         overflow_d = 1'b0;
      end

      if (complete) begin
         if ((state_q == StEmpty) || ack) begin
            data_d  = asm_d;
            state_d = StFull;
         end else begin
            overflow_d = 1'b1;
         end
      end else if ((state_q == StFull) && ack) begin
         state_d = StEmpty;
      end

      if ((TIMEOUT_CYC == 0) || tick || (idx_q == '0) || expire) begin
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + IW'(1);
      end

      timeout_d = expire;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StEmpty;
         asm_q      <= '0;
         data_q     <= '0;
         idx_q      <= '0;
         idle_cnt_q <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         asm_q      <= asm_d;
         data_q     <= data_d;
         idx_q      <= idx_d;
         idle_cnt_q <= idle_cnt_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   assign data     = data_q;
   assign valid    = (state_q == StFull);
   assign count    = idx_q;
   assign overflow = overflow_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_ps2_frame_assembler.sv
// Two assembler configurations share one random byte stream; a frame-level model feeds a
// scoreboard queue per instance and a negedge monitor compares every cycle.
module tb_ps2_frame_assembler;

   logic        clk = 1'b0;
   logic        reset, tick, ack, clear_ovf;
   logic [7:0]  d;

   logic [31:0] data_a;
   logic        valid_a, overflow_a, timeout_a;
   logic [2:0]  count_a;
   logic [23:0] data_b;
   logic        valid_b, overflow_b, timeout_b;
   logic [1:0]  count_b;

   always #5 clk = ~clk;

   ps2_frame_assembler #(.NBYTES(4), .DW(8), .ORDER(0), .TIMEOUT_CYC(10)) dut_a (
      .clk(clk), .reset(reset), .tick(tick), .d(d), .ack(ack), .clear_ovf(clear_ovf),
      .data(data_a), .valid(valid_a), .count(count_a), .overflow(overflow_a),
      .timeout(timeout_a)
   );

   ps2_frame_assembler #(.NBYTES(3), .DW(8), .ORDER(1), .TIMEOUT_CYC(0)) dut_b (
      .clk(clk), .reset(reset), .tick(tick), .d(d), .ack(ack), .clear_ovf(clear_ovf),
      .data(data_b), .valid(valid_b), .count(count_b), .overflow(overflow_b),
      .timeout(timeout_b)
   );

   function automatic int unsigned nb_of(input int i);
      return (i == 0) ? 4 : 3;
   endfunction
   function automatic int unsigned ord_of(input int i);
      return (i == 0) ? 0 : 1;
   endfunction
   function automatic int unsigned tmo_of(input int i);
      return (i == 0) ? 10 : 0;
   endfunction

   // Reference model state: bytes of the current partial frame and the held-frame flag.
   logic [7:0]       part [2][8];
   int unsigned      plen [2];
   logic             hv [2];
   logic             m_ovf [2];
   logic             m_to [2];
   longint unsigned  last_edge [2];
   longint unsigned  edge_n;
   logic [63:0]      qa [$];
   logic [63:0]      qb [$];
   int               n_checks = 0;
   int               n_fail = 0;
   bit               mon_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] assemble(input int i);
      logic [63:0] f;
      f = '0;
      for (int j = 0; j < int'(nb_of(i)); j++) begin
         if (ord_of(i) == 0) f = (f << 8) | 64'(part[i][j]);
         else f = f | (64'(part[i][j]) << (8 * j));
      end
      return f;
   endfunction

   task automatic model_step(input int i);
      logic [63:0] f;
      bit          done;
      done    = 1'b0;
      m_to[i] = 1'b0;
      if (reset) begin
         plen[i]  = 0;
         hv[i]    = 1'b0;
         m_ovf[i] = 1'b0;
         if (i == 0) qa.delete();
         else qb.delete();
         return;
      end
      if (clear_ovf) m_ovf[i] = 1'b0;
      if (tick) begin
         part[i][plen[i]] = d;
         plen[i]++;
         last_edge[i] = edge_n;
         if (plen[i] == nb_of(i)) begin
            done    = 1'b1;
            plen[i] = 0;
            f       = assemble(i);
            if (!hv[i] || ack) begin
               hv[i] = 1'b1;
               if (i == 0) qa.push_back(f);
               else qb.push_back(f);
            end else begin
               m_ovf[i] = 1'b1;
            end
         end
      end
      if (!done && hv[i] && ack) hv[i] = 1'b0;
      if (!tick && (tmo_of(i) > 0) && (plen[i] > 0) &&
          (edge_n - last_edge[i] == longint'(tmo_of(i)))) begin
         plen[i] = 0;
         m_to[i] = 1'b1;
      end
   endtask

   initial begin
      edge_n = 0;
      for (int i = 0; i < 2; i++) begin
         plen[i] = 0; hv[i] = 1'b0; m_ovf[i] = 1'b0; m_to[i] = 1'b0; last_edge[i] = 0;
      end
      forever begin
         @(posedge clk);
         edge_n++;
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   // Monitor: outputs are stable at the falling edge; a handshake retires the front frame.
   initial forever begin
      @(negedge clk);
      if (mon_on) begin
         check("valid_a", 64'(valid_a), 64'(hv[0]));
         check("count_a", 64'(count_a), 64'(plen[0]));
         check("overflow_a", 64'(overflow_a), 64'(m_ovf[0]));
         check("timeout_a", 64'(timeout_a), 64'(m_to[0]));
         check("valid_b", 64'(valid_b), 64'(hv[1]));
         check("count_b", 64'(count_b), 64'(plen[1]));
         check("overflow_b", 64'(overflow_b), 64'(m_ovf[1]));
         check("timeout_b", 64'(timeout_b), 64'(m_to[1]));
         if (hv[0]) begin
            if (qa.size() == 0) check("frame_a_queued", 64'(0), 64'(1));
            else begin
               check("data_a", 64'(data_a), qa[0]);
               if (ack && !reset) void'(qa.pop_front());
            end
         end
         if (hv[1]) begin
            if (qb.size() == 0) check("frame_b_queued", 64'(0), 64'(1));
            else begin
               check("data_b", 64'(data_b), qb[0]);
               if (ack && !reset) void'(qb.pop_front());
            end
         end
      end
   end

   task automatic drive(input logic r, input logic t, input logic [7:0] b, input logic a,
                        input logic c);
      reset = r; tick = t; d = b; ack = a; clear_ovf = c;
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] b, input logic a);
      drive(1'b0, 1'b1, b, a, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] seq [4];
      logic [2:0] exp_cnt [4];
      int         burst;
      logic       r, t;

      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      mon_on = 1'b1;
      drive(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
      check("rst_data", 64'(data_a), 64'(0));
      check("rst_valid", 64'(valid_a), 64'(0));
      check("rst_count", 64'(count_a), 64'(0));
      check("rst_ovf", 64'(overflow_a), 64'(0));
      check("rst_timeout", 64'(timeout_a), 64'(0));

      seq = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd0};
      for (int k = 0; k < 4; k++) begin
         send(seq[k], 1'b0);
         check("order0_count", 64'(count_a), 64'(exp_cnt[k]));
         if (k == 2) check("order1_n3_data", 64'(data_b), 64'h332211);
      end
      check("order0_data", 64'(data_a), 64'h11223344);
      check("order0_valid", 64'(valid_a), 64'(1));
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         send(8'(k), 1'b0);
         if (k == 4) check("held_data", 64'(data_a), 64'h01020304);
         if (k == 7) check("ovf_before", 64'(overflow_a), 64'(0));
      end
      check("ovf_set", 64'(overflow_a), 64'(1));
      check("ovf_data_kept", 64'(data_a), 64'h01020304);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_cleared", 64'(overflow_a), 64'(0));

      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) send(8'(k), 1'b0);
      send(8'h08, 1'b1);
      check("ack_swap_data", 64'(data_a), 64'h05060708);
      check("ack_swap_valid", 64'(valid_a), 64'(1));
      check("ack_swap_ovf", 64'(overflow_a), 64'(0));
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      for (int j = 1; j <= 11; j++) begin
         idle(1);
         check("to_pulse", 64'(timeout_a), 64'(j == 10));
         check("to_count", 64'(count_a), (j >= 10) ? 64'(0) : 64'(2));
      end
      seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int k = 0; k < 4; k++) send(seq[k], 1'b0);
      check("after_to_data", 64'(data_a), 64'hDEADBEEF);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      idle(9);
      send(8'h03, 1'b0);
      check("tick_wins_timeout", 64'(timeout_a), 64'(0));
      check("tick_wins_count", 64'(count_a), 64'(3));
      idle(12);

      for (int k = 0; k < 7; k++) send(8'(8'h90 + k), 1'b0);
      check("pre_reset_valid", 64'(valid_a), 64'(1));
      drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
      check("midrst_data", 64'(data_a), 64'(0));
      check("midrst_valid", 64'(valid_a), 64'(0));
      check("midrst_count", 64'(count_a), 64'(0));
      check("midrst_ovf", 64'(overflow_a), 64'(0));
      seq = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
      for (int k = 0; k < 4; k++) send(seq[k], 1'b0);
      check("clean_frame", 64'(data_a), 64'hCAFEF00D);

      burst = 0;
      for (int n = 0; n < 4000; n++) begin
         r = ($urandom_range(0, 199) == 0);
         if (burst > 0) begin
            burst--;
            t = 1'b0;
         end else if ($urandom_range(0, 99) < 3) begin
            burst = $urandom_range(7, 12);
            t = 1'b0;
         end else begin
            t = ($urandom_range(0, 99) < 60);
         end
         drive(r, t, 8'($urandom), ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 5));
      end
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
